// File: rtl/fill_rect_addr_engine_if.sv
// Command-FIFO / data-generator handshake bundle for the fill-rect address engine.
// The master modport is the surrounding logic (FIFO + generator). The slave modport is the engine.
interface fill_rect_addr_engine_if;
  logic        cmd_fifo_rts;
  logic        cmd_fifo_rtr;
  logic [15:0] cmd_x;
  logic [15:0] cmd_y;
  logic [15:0] cmd_wid;
  logic [15:0] cmd_hgt;
  logic [3:0]  cmd_rval;
  logic [3:0]  cmd_gval;
  logic [3:0]  cmd_bval;
  logic        fill_rect_data_gen_start_strobe;
  logic [15:0] init_addr;
  logic [15:0] cmd_data_wid;
  logic [15:0] cmd_data_hgt;
  logic [3:0]  cmd_data_rval;
  logic [3:0]  cmd_data_gval;
  logic [3:0]  cmd_data_bval;
  logic        gen_busy;
  logic        cmd_drop_strobe;
  logic        rect_done_strobe;

  modport master (
    output cmd_fifo_rts, cmd_x, cmd_y, cmd_wid, cmd_hgt, cmd_rval, cmd_gval, cmd_bval, gen_busy,
    input  cmd_fifo_rtr, fill_rect_data_gen_start_strobe, init_addr, cmd_data_wid, cmd_data_hgt,
           cmd_data_rval, cmd_data_gval, cmd_data_bval, cmd_drop_strobe, rect_done_strobe
  );

  modport slave (
    input  cmd_fifo_rts, cmd_x, cmd_y, cmd_wid, cmd_hgt, cmd_rval, cmd_gval, cmd_bval, gen_busy,
    output cmd_fifo_rtr, fill_rect_data_gen_start_strobe, init_addr, cmd_data_wid, cmd_data_hgt,
           cmd_data_rval, cmd_data_gval, cmd_data_bval, cmd_drop_strobe, rect_done_strobe
  );
endinterface

// File: rtl/fill_rect_addr_engine.sv
// Fill-rect address engine: accepts one command, clips it to the screen, computes the start word
// address and hands the latched fields to the data generator, one rectangle at a time.
module fill_rect_addr_engine #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 272,
  parameter int unsigned ROW_STRIDE = 240
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  fill_rect_addr_engine_if.slave  io_bus
);

  typedef enum logic [2:0] {
    StIdle, StCalc, StStart, StWaitAck, StWaitDone, StDrop
  } state_e;

  localparam logic [15:0] StrideBits = 16'(ROW_STRIDE);
  localparam logic [16:0] ScreenW17  = 17'(SCREEN_W);
  localparam logic [16:0] ScreenH17  = 17'(SCREEN_H);

  state_e      r_state, w_state_d;
  logic        r_rtr, r_start, r_drop, r_done;
  logic        w_rtr_d, w_start_d, w_drop_d, w_done_d;
  logic        w_accept;
  logic [15:0] r_x, r_y, r_wid, r_hgt;
  logic [3:0]  r_rval, r_gval, r_bval;
  logic [15:0] r_init_addr, r_out_wid, r_out_hgt;
  logic [3:0]  r_out_rval, r_out_gval, r_out_bval;

  logic        w_reject;
  logic [16:0] w_wid_room, w_hgt_room;
  logic [15:0] w_clip_wid, w_clip_hgt;
  logic [15:0] w_row_off, w_col_grp, w_col_off, w_init_addr;

  assign w_accept = io_bus.cmd_fifo_rts & r_rtr;

  // Clip arithmetic in 17 bits so x+wid / y+hgt can never wrap.
  assign w_reject   = (r_wid == 16'd0) | (r_hgt == 16'd0) |
                      ({1'b0, r_x} >= ScreenW17) | ({1'b0, r_y} >= ScreenH17);
  assign w_wid_room = ScreenW17 - {1'b0, r_x};
  assign w_hgt_room = ScreenH17 - {1'b0, r_y};
  assign w_clip_wid = ({1'b0, r_wid} > w_wid_room) ? w_wid_room[15:0] : r_wid;
  assign w_clip_hgt = ({1'b0, r_hgt} > w_hgt_room) ? w_hgt_room[15:0] : r_hgt;

  // y * ROW_STRIDE as a constant shift-add sum; no multiplier is inferred.
  always_comb begin
    w_row_off = '0;
    for (int i = 0; i < 16; i++) begin
      if (StrideBits[i]) w_row_off = w_row_off + (r_y << i);
    end
  end

  assign w_col_grp   = {3'b000, r_x[15:3]};
  assign w_col_off   = (w_col_grp << 1) + w_col_grp;
  assign w_init_addr = w_row_off + w_col_off;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_rtr   <= 1'b0;
      r_start <= 1'b0;
      r_drop  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_rtr   <= w_rtr_d;
      r_start <= w_start_d;
      r_drop  <= w_drop_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:     if (w_accept) w_state_d = StCalc;
      StCalc:     w_state_d = w_reject ? StDrop : StStart;
      StStart:    w_state_d = StWaitAck;
      StWaitAck:  if (io_bus.gen_busy) w_state_d = StWaitDone;
      StWaitDone: if (!io_bus.gen_busy) w_state_d = StIdle;
      StDrop:     w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from the current state, so each lags its state by one cycle.
  always_comb begin
    w_rtr_d   = (r_state == StIdle) & ~w_accept;
    w_start_d = (r_state == StStart) | ((r_state == StWaitAck) & ~io_bus.gen_busy);
    w_drop_d  = (r_state == StDrop);
    w_done_d  = (r_state == StWaitDone) & ~io_bus.gen_busy;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_wid       <= '0;
      r_hgt       <= '0;
      r_rval      <= '0;
      r_gval      <= '0;
      r_bval      <= '0;
      r_init_addr <= '0;
      r_out_wid   <= '0;
      r_out_hgt   <= '0;
      r_out_rval  <= '0;
      r_out_gval  <= '0;
      r_out_bval  <= '0;
    end else begin
      if (w_accept) begin
        r_x    <= io_bus.cmd_x;
        r_y    <= io_bus.cmd_y;
        r_wid  <= io_bus.cmd_wid;
        r_hgt  <= io_bus.cmd_hgt;
        r_rval <= io_bus.cmd_rval;
        r_gval <= io_bus.cmd_gval;
        r_bval <= io_bus.cmd_bval;
      end
      if ((r_state == StCalc) && !w_reject) begin
        r_init_addr <= w_init_addr;
        r_out_wid   <= w_clip_wid;
        r_out_hgt   <= w_clip_hgt;
        r_out_rval  <= r_rval;
        r_out_gval  <= r_gval;
        r_out_bval  <= r_bval;
      end
    end
  end

  assign io_bus.cmd_fifo_rtr                    = r_rtr;
  assign io_bus.fill_rect_data_gen_start_strobe = r_start;
  assign io_bus.cmd_drop_strobe                 = r_drop;
  assign io_bus.rect_done_strobe                = r_done;
  assign io_bus.init_addr                       = r_init_addr;
  assign io_bus.cmd_data_wid                    = r_out_wid;
  assign io_bus.cmd_data_hgt                    = r_out_hgt;
  assign io_bus.cmd_data_rval                   = r_out_rval;
  assign io_bus.cmd_data_gval                   = r_out_gval;
  assign io_bus.cmd_data_bval                   = r_out_bval;

endmodule
